serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_fulladder.sv | 20 ++
 rtl/serial_adder.sv | 102 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fulladder.sv
// Gate-level one-bit full-adder cell used as the serial adder's datapath.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic axb;
    logic g;
    logic p;

    xor u_x0 (axb, a, b);
    xor u_x1 (sum, axb, cin);
    and u_a0 (g, a, b);
    and u_a1 (p, axb, cin);
    or  u_o0 (cout, g, p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, WIDTH shift cycles per addition.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    count;
    logic             fa_sum;
    logic             fa_cout;

    fulladder u_fa (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = {fa_sum, res_reg[WIDTH-1:1]};

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            count   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        carry   <= cin;
                        res_reg <= '0;
                        count   <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_reg   <= {1'b0, a_reg[WIDTH-1:1]};
                    b_reg   <= {1'b0, b_reg[WIDTH-1:1]};
                    carry   <= fa_cout;
                    res_reg <= res_next;
                    count   <= count + 1'b1;
                    if (count == LAST) begin
                        // Final bit: carry is the carry into the MSB here.
                        sum   <= res_next;
                        cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= carry ^ fa_cout;
`endif
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
